dmem_responder: RTL

- Data-memory responder for the pipelined core's data-memory port (memRead/memWrite/address/writeData/readData).
- Adds multi-cycle access latency with a ready/readValid handshake, so the datapath can be exercised against a non-ideal memory.
- Includes a sequential debug dump engine that streams the whole array out one word per cycle.

---
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: data-memory responder with configurable access latency,
// ready/readValid handshake and a sequential debug dump engine.
// Optional feature: define DMEM_BYTEEN_EN to add a per-byte write strobe.
module dmem_responder #(
   parameter int N       = 64,
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] address,
   input  logic [N-1:0]      writeData,
`ifdef DMEM_BYTEEN_EN
   input  logic [N/8-1:0]    writeStrobe,
`endif
   output logic [N-1:0]      readData,
   output logic              ready,
   output logic              readValid,
   input  logic              dump,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [N-1:0]      dump_data,
   output logic              dump_done
);

   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   // DONE is the single cycle after the last dumped word, used to pulse dump_done.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DUMP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          cnt;
   logic                lat_wr;
   logic [ADDR_W-1:0]   lat_addr;
   logic [N-1:0]        lat_data;
   logic [ADDR_W-1:0]   idx;
   logic                dump_q;
   logic                dump_rise;
   logic                accept;
   logic                complete;
   logic                dump_start;
   logic [N-1:0]        mem [DEPTH];

`ifdef DMEM_BYTEEN_EN
   logic [N/8-1:0]      lat_strb;

   // Replace only the strobed bytes of the stored word.
   function automatic logic [N-1:0] merge_bytes(input logic [N-1:0]   old_word,
                                                input logic [N-1:0]   new_word,
                                                input logic [N/8-1:0] strb);
      logic [N-1:0] res;
      res = old_word;
      for (int b = 0; b < N/8; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return res;
   endfunction
`endif

   assign dump_rise = dump & ~dump_q;
   // A dump edge in IDLE wins over a request so the dump cannot be starved.
   assign ready     = (state == IDLE) & ~dump_rise;

   // Next-state logic and the one-cycle control strobes derived from it.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      complete   = 1'b0;
      dump_start = 1'b0;
      case (state)
         IDLE: begin
            if (ready && (memRead || memWrite)) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end else if (dump_rise) begin
               dump_start = 1'b1;
               state_nxt  = DUMP;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         DUMP: begin
            if (idx == LAST_IDX) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any access or dump in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Control registers, handshake outputs and dump engine outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= 4'd0;
         lat_wr     <= 1'b0;
         idx        <= '0;
         dump_q     <= 1'b0;
         readData   <= '0;
         readValid  <= 1'b0;
         dump_valid <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         dump_done  <= 1'b0;
      end else begin
         dump_q     <= dump;
         readValid  <= complete & ~lat_wr;
         dump_valid <= (state == DUMP);
         dump_done  <= (state == DONE);
         if (accept) begin
            cnt    <= CNT_INIT;
            lat_wr <= memWrite;
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (complete && !lat_wr) readData <= mem[lat_addr];
         if (state == DUMP) begin
            dump_addr <= idx;
            dump_data <= mem[idx];
            idx       <= idx + 1'b1;
         end else if (dump_start) begin
            idx <= '0;
         end
      end
   end

   // Request payload latched at accept so the initiator may change inputs while busy.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_addr <= address;
         lat_data <= writeData;
`ifdef DMEM_BYTEEN_EN
         lat_strb <= writeStrobe;
`endif
      end
   end

   // Storage array; a write commits only in its completion cycle.
   always_ff @(posedge clk) begin
      if (complete && lat_wr) begin
`ifdef DMEM_BYTEEN_EN
         mem[lat_addr] <= merge_bytes(mem[lat_addr], lat_data, lat_strb);
`else
         mem[lat_addr] <= lat_data;
`endif
      end
   end

endmodule
